// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an A5-framed image over 8N1 serial, writes it into instruction memory
// and releases the CPU once the XOR checksum matches. Optional inter-byte timeout: BOOT_TIMEOUT_EN.
module uart_boot_loader #(
  parameter int CLK_FREQ       = 100000000,
  parameter int BAUD           = 115200,
  parameter int IMEM_WORDS     = 256,
  parameter int TIMEOUT_CYCLES = 10000000,
  localparam int AW            = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          boot_done,
  output logic          boot_err
);

  localparam int          CPB     = CLK_FREQ / BAUD;
  localparam logic [15:0] CPB_M1  = 16'(CPB - 1);
  localparam logic [15:0] HALF_M1 = 16'(CPB / 2 - 1);
  localparam logic [31:0] N_MAX   = 32'(IMEM_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_e;
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR} st_e;

  logic        rx_s1_q, rx_s2_q;
  rx_st_e      rx_st_q, rx_st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        vld_q, vld_d, ferr_q, ferr_d;

  st_e           st_q, st_d;
  logic [15:0]   len_q, len_d, n_w;
  logic [31:0]   asm_q, asm_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [15:0]   widx_q, widx_d;
  logic [7:0]    csum_q, csum_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          to_hit;

  // Receiver: start bit re-checked at mid-bit, then one full bit period per sample.
  always_comb begin
    rx_st_d = rx_st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (rx_st_q)
      R_IDLE: if (!rx_s2_q) begin
        rx_st_d = R_START;
        cnt_d   = '0;
      end
      R_START: if (cnt_q == HALF_M1) begin
        cnt_d   = '0;
        bit_d   = '0;
        rx_st_d = rx_s2_q ? R_IDLE : R_DATA;
      end else cnt_d = cnt_q + 16'd1;
      R_DATA: if (cnt_q == CPB_M1) begin
        cnt_d = '0;
        sh_d  = {rx_s2_q, sh_q[7:1]};
        if (bit_q == 3'd7) rx_st_d = R_STOP;
        else bit_d = bit_q + 3'd1;
      end else cnt_d = cnt_q + 16'd1;
      R_STOP: if (cnt_q == CPB_M1) begin
        rx_st_d = R_IDLE;
        vld_d   = rx_s2_q;
        ferr_d  = !rx_s2_q;
      end else cnt_d = cnt_q + 16'd1;
      default: rx_st_d = R_IDLE;
    endcase
  end

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] to_q, to_d;
  logic        waiting;
  assign waiting = (st_q == S_LEN_LO) || (st_q == S_LEN_HI) || (st_q == S_DATA) || (st_q == S_CHECK);
  assign to_d    = (!waiting || vld_q || ferr_q) ? 32'd0 : to_q + 32'd1;
  assign to_hit  = waiting && !vld_q && !ferr_q && (to_q == 32'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (!rst) to_q <= '0;
    else      to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  assign n_w = {sh_q, len_q[7:0]};

  always_comb begin
    st_d    = st_q;
    len_d   = len_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    widx_d  = widx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (vld_q) begin
      case (st_q)
        S_IDLE: if (sh_q == 8'hA5) st_d = S_LEN_LO;
        S_LEN_LO: begin
          len_d = {8'h00, sh_q};
          st_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d = n_w;
          if (n_w != 16'd0 && {16'd0, n_w} <= N_MAX) begin
            st_d   = S_DATA;
            widx_d = '0;
            bcnt_d = '0;
            csum_d = '0;
          end else st_d = S_ERR;
        end
        S_DATA: begin
          asm_d  = {sh_q, asm_q[31:8]};
          csum_d = csum_q ^ sh_q;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q[AW-1:0];
            wdata_d = {sh_q, asm_q[31:8]};
            widx_d  = widx_q + 16'd1;
            if (widx_q == len_q - 16'd1) st_d = S_CHECK;
          end
        end
        S_CHECK: st_d = (sh_q == csum_q) ? S_DONE : S_ERR;
        S_ERR: if (sh_q == 8'hA5) begin
          st_d   = S_LEN_LO;
          widx_d = '0;
          csum_d = '0;
          bcnt_d = '0;
        end
        default: ;
      endcase
    end
    // A corrupt frame or a stalled link aborts the load unless the image is already accepted.
    if ((ferr_q && st_q != S_DONE) || to_hit) st_d = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_st_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      st_q    <= S_IDLE;
      len_q   <= '0;
      asm_q   <= '0;
      bcnt_q  <= '0;
      widx_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      st_q    <= st_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      bcnt_q  <= bcnt_d;
      widx_q  <= widx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (st_q != S_DONE);
  assign boot_done  = (st_q == S_DONE);
  assign boot_err   = (st_q == S_ERR);

endmodule
